// File: rtl/slot_fill_sched_pkg.sv
// Shared ISA decode constants, scheduler FSM encoding and control-flow classifiers.
// The decode helpers are shared with the decode stage so both agree on what counts as control flow.
package slot_fill_sched_pkg;

  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] INST_NOP   = 32'h0000_0013;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SLOT = 1'b1
  } sched_state_t;

  function automatic logic is_cbranch(input logic [6:0] opcode);
    return opcode == OPC_BRANCH;
  endfunction

  function automatic logic is_ctrl(input logic [6:0] opcode);
    return (opcode == OPC_BRANCH) || (opcode == OPC_JAL) || (opcode == OPC_JALR);
  endfunction

  function automatic logic is_system(input logic [6:0] opcode);
    return opcode == OPC_SYSTEM;
  endfunction

endpackage

// File: rtl/slot_fill_sched_sat_counter.sv
// Width-parameterised saturating event counter: sticks at all-ones, never wraps.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/slot_fill_sched.sv
// Delay-slot filler: promotes the fall-through instruction into a NOP delay slot behind a
// conditional branch, and annuls it when that branch resolves taken.
module slot_fill_sched
  import slot_fill_sched_pkg::*;
#(
  parameter bit ENABLE = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             branch_redirect,
  input  logic [31:0]      id_instr,
  input  logic             cand0_valid,
  input  logic [31:0]      cand0_instr,
  input  logic             cand1_valid,
  input  logic [31:0]      cand1_instr,
  input  logic [31:0]      cand1_pc,
  input  logic             branch_resolved,
  input  logic             branch_taken,
  output logic             kill_cand1,
  output logic             sub_valid,
  output logic [31:0]      sub_instr,
  output logic [31:0]      sub_pc,
  output logic             annul_slot,
  output logic [CNT_W-1:0] fill_count,
  output logic [CNT_W-1:0] annul_count
);

  sched_state_t state;
  logic [31:0]  hold_instr;
  logic [31:0]  hold_pc;
  logic         taken_seen;

  logic in_slot;
  logic id_is_cbranch;
  logic cand0_is_nop;
  logic cand1_eligible;
  logic fill_cond;
  logic taken_now;
  logic annul_inc;
  logic unused_id_bits;

  assign unused_id_bits = ^id_instr[31:7];

  assign in_slot        = (state == ST_SLOT);
  assign id_is_cbranch  = is_cbranch(id_instr[6:0]);
  assign cand0_is_nop   = (cand0_instr == INST_NOP);
  assign cand1_eligible = !is_ctrl(cand1_instr[6:0]) && !is_system(cand1_instr[6:0])
                          && (cand1_instr != INST_NOP);

  assign fill_cond = ENABLE && !stall && !flush && !branch_redirect && id_is_cbranch
                     && cand0_valid && cand0_is_nop && cand1_valid && cand1_eligible;

  // Fills are only evaluated from IDLE; while the slot is occupied fetch keeps cand1.
  assign kill_cand1 = !in_slot && fill_cond;

  assign taken_now  = branch_resolved && branch_taken;
  assign annul_slot = in_slot && (taken_seen || taken_now);

  assign sub_valid  = in_slot;
  assign sub_instr  = in_slot ? hold_instr : INST_NOP;
  assign sub_pc     = in_slot ? hold_pc    : 32'h0;

  // A slot flushed away never reached retirement, so it is not counted as annulled.
  assign annul_inc = in_slot && !flush && !stall && annul_slot;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      hold_instr <= INST_NOP;
      hold_pc    <= 32'h0;
      taken_seen <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fill_cond) begin
            state      <= ST_SLOT;
            hold_instr <= cand1_instr;
            hold_pc    <= cand1_pc;
            taken_seen <= 1'b0;
          end
        end
        ST_SLOT: begin
          if (taken_now) begin
            taken_seen <= 1'b1;
          end
          if (flush || !stall) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_fill_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (kill_cand1),
    .count (fill_count)
  );

  sat_counter #(.W(CNT_W)) u_annul_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (annul_inc),
    .count (annul_count)
  );

endmodule

// File: tb/tb_slot_fill_sched.sv
// Randomized bench for slot_fill_sched against a cycle-level reference model of the fill rules.
module tb_slot_fill_sched;

  localparam int          CW    = 3;
  localparam logic [31:0] CMAX  = 32'd7;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ADD   = 32'h0073_02B3;  // add x5,x6,x7
  localparam logic [31:0] BEQ   = 32'h0020_8463;  // beq x1,x2,+8
  localparam logic [31:0] JAL   = 32'h0100_00EF;
  localparam logic [31:0] JALR  = 32'h0000_80E7;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic clk = 1'b0;
  logic reset, stall, flush, branch_redirect;
  logic [31:0] id_instr, cand0_instr, cand1_instr, cand1_pc;
  logic cand0_valid, cand1_valid, branch_resolved, branch_taken;

  logic kill_cand1, sub_valid, annul_slot;
  logic [31:0] sub_instr, sub_pc;
  logic [CW-1:0] fill_count, annul_count;

  logic d_kill, d_sub_valid, d_annul;
  logic [31:0] d_sub_instr, d_sub_pc;
  logic [CW-1:0] d_fill, d_annul_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state: is a promoted instruction sitting in decode, and what is it.
  bit          m_slot;
  logic [31:0] m_instr, m_pc;
  bit          m_taken;
  logic [31:0] m_fill, m_annul;

  always #5 clk = ~clk;

  slot_fill_sched #(.ENABLE(1'b1), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .branch_redirect(branch_redirect),
    .id_instr(id_instr), .cand0_valid(cand0_valid), .cand0_instr(cand0_instr),
    .cand1_valid(cand1_valid), .cand1_instr(cand1_instr), .cand1_pc(cand1_pc),
    .branch_resolved(branch_resolved), .branch_taken(branch_taken),
    .kill_cand1(kill_cand1), .sub_valid(sub_valid), .sub_instr(sub_instr), .sub_pc(sub_pc),
    .annul_slot(annul_slot), .fill_count(fill_count), .annul_count(annul_count)
  );

  slot_fill_sched #(.ENABLE(1'b0), .CNT_W(CW)) dut_off (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .branch_redirect(branch_redirect),
    .id_instr(id_instr), .cand0_valid(cand0_valid), .cand0_instr(cand0_instr),
    .cand1_valid(cand1_valid), .cand1_instr(cand1_instr), .cand1_pc(cand1_pc),
    .branch_resolved(branch_resolved), .branch_taken(branch_taken),
    .kill_cand1(d_kill), .sub_valid(d_sub_valid), .sub_instr(d_sub_instr), .sub_pc(d_sub_pc),
    .annul_slot(d_annul), .fill_count(d_fill), .annul_count(d_annul_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ctrl_or_sys(input logic [31:0] ins);
    return ins[6:0] == 7'h63 || ins[6:0] == 7'h6F || ins[6:0] == 7'h67 || ins[6:0] == 7'h73;
  endfunction

  // Compare outputs mid-cycle with inputs settled, then advance the model past the clock edge.
  task automatic step();
    bit fill, taken_now, exp_annul;
    #4;
    fill = !stall && !flush && !branch_redirect && id_instr[6:0] == 7'h63
           && cand0_valid && cand0_instr == NOP && cand1_valid
           && !ctrl_or_sys(cand1_instr) && cand1_instr != NOP;
    taken_now = branch_resolved && branch_taken;
    exp_annul = m_slot && (m_taken || taken_now);

    check("kill_cand1",  32'(kill_cand1),  32'(!m_slot && fill));
    check("sub_valid",   32'(sub_valid),   32'(m_slot));
    check("sub_instr",   sub_instr,        m_slot ? m_instr : NOP);
    check("sub_pc",      sub_pc,           m_slot ? m_pc : 32'h0);
    check("annul_slot",  32'(annul_slot),  32'(exp_annul));
    check("fill_count",  32'(fill_count),  m_fill);
    check("annul_count", 32'(annul_count), m_annul);
    check("off_kill",    32'(d_kill),      32'h0);
    check("off_sub",     32'(d_sub_valid), 32'h0);
    check("off_fill",    32'(d_fill),      32'h0);

    if (reset) begin
      m_slot = 0; m_instr = NOP; m_pc = 0; m_taken = 0; m_fill = 0; m_annul = 0;
    end else if (m_slot) begin
      if (taken_now) m_taken = 1;
      if (flush) m_slot = 0;
      else if (!stall) begin
        if (exp_annul && m_annul != CMAX) m_annul++;
        m_slot = 0;
      end
    end else if (fill) begin
      m_slot = 1; m_instr = cand1_instr; m_pc = cand1_pc; m_taken = 0;
      if (m_fill != CMAX) m_fill++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_fill_setup(input logic [31:0] c1, input logic [31:0] pc);
    reset = 0; stall = 0; flush = 0; branch_redirect = 0;
    id_instr = BEQ; cand0_valid = 1; cand0_instr = NOP;
    cand1_valid = 1; cand1_instr = c1; cand1_pc = pc;
    branch_resolved = 0; branch_taken = 0;
  endtask

  task automatic rand_inputs();
    logic [31:0] pick [6];
    pick[0] = ADD; pick[1] = JAL; pick[2] = JALR; pick[3] = ECALL; pick[4] = NOP;
    pick[5] = {$urandom() & 32'hFFFF_FF80} | 32'h33;
    reset           = ($urandom_range(0, 99) < 2);
    stall           = ($urandom_range(0, 99) < 30);
    flush           = ($urandom_range(0, 99) < 6);
    branch_redirect = ($urandom_range(0, 99) < 6);
    id_instr        = ($urandom_range(0, 99) < 70) ? BEQ : pick[$urandom_range(0, 5)];
    cand0_valid     = ($urandom_range(0, 99) < 85);
    cand0_instr     = ($urandom_range(0, 99) < 80) ? NOP : ADD;
    cand1_valid     = ($urandom_range(0, 99) < 85);
    cand1_instr     = ($urandom_range(0, 99) < 55) ? pick[5] : pick[$urandom_range(0, 4)];
    cand1_pc        = $urandom() & 32'hFFFF_FFFC;
    branch_resolved = ($urandom_range(0, 99) < 35);
    branch_taken    = $urandom_range(0, 1) == 1;
  endtask

  initial begin
    set_fill_setup(ADD, 32'h10);
    id_instr = ADD;
    reset = 1;
    step();
    step();

    // Plain fill, then a not-taken resolution releases the ADD without annul.
    set_fill_setup(ADD, 32'h10);
    step();
    id_instr = NOP; cand0_valid = 0; cand1_valid = 0;
    branch_resolved = 1; branch_taken = 0;
    step();

    // Fill, stall three cycles with a taken resolution in the first, then release.
    set_fill_setup(ADD, 32'h20);
    step();
    id_instr = NOP; stall = 1; branch_resolved = 1; branch_taken = 1;
    step();
    branch_resolved = 0;
    step();
    step();
    stall = 0;
    step();

    // Blocked fills: JAL candidate, non-NOP cand0, cand1 invalid, flush, redirect.
    set_fill_setup(JAL, 32'h30); step();
    set_fill_setup(ADD, 32'h30); cand0_instr = ADD; step();
    set_fill_setup(ADD, 32'h30); cand1_valid = 0; step();
    set_fill_setup(ADD, 32'h30); flush = 1; step();
    set_fill_setup(ADD, 32'h30); branch_redirect = 1; step();

    // Flush inside the slot, then reset inside the slot.
    set_fill_setup(ADD, 32'h40); step();
    id_instr = NOP; flush = 1; stall = 1; step();
    set_fill_setup(ADD, 32'h44); step();
    reset = 1; step();
    set_fill_setup(ADD, 32'h48); id_instr = NOP; step();

    // Enough back-to-back fills to drive fill_count into saturation.
    for (int i = 0; i < 10; i++) begin
      set_fill_setup(ADD, 32'h100 + 32'(i * 4)); step();
      id_instr = NOP; step();
    end

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/slot_fill_sched.md
Name: slot_fill_sched

Overview:
Delay-slot scheduler that consumes the fetch stage's decode-register instruction and its two-entry lookahead buffer (cand0/cand1). When a conditional branch sits in decode, its delay slot (cand0) is a NOP, and the following fall-through instruction (cand1) is eligible, the block promotes cand1 into the slot. It asserts kill_cand1 back to fetch and later drives a substitution into the decode mux. Because the filled instruction comes from the fall-through path, the block annuls it if the branch resolves taken.

Parameters:
ENABLE, 1, 0 disables all filling: kill_cand1 and sub_valid stay 0, counters frozen.
CNT_W, 16, width of the saturating statistics counters.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
stall  in  1  pipeline stall; decode register holds
flush  in  1  pipeline flush
branch_redirect  in  1  fetch redirect this cycle
id_instr  in  32  instruction in the decode register (fetch if_instr)
cand0_valid  in  1  lookahead slot 0 valid
cand0_instr  in  32  lookahead slot 0 instruction
cand1_valid  in  1  lookahead slot 1 valid
cand1_instr  in  32  lookahead slot 1 instruction
cand1_pc  in  32  lookahead slot 1 PC
branch_resolved  in  1  branch in EX resolved this cycle
branch_taken  in  1  resolution outcome, qualified by branch_resolved
kill_cand1  out  1  combinational; removes cand1 from the fetch buffer
sub_valid  out  1  decode must replace id_instr with sub_instr
sub_instr  out  32  promoted instruction
sub_pc  out  32  promoted instruction PC
annul_slot  out  1  decode must convert the substituted instruction to NOP
fill_count  out  CNT_W  fills performed, saturating
annul_count  out  CNT_W  fills annulled, saturating

Behaviour:
- Decoding uses the shared ISA macros.
- id_is_cbranch: opcode is a conditional branch. Jumps, JAL and JALR are excluded.
- cand0_is_nop: cand0_instr equals the INST_NOP encoding.
- cand1_eligible: cand1 is not a branch, jump or system instruction, and is not INST_NOP.
- FSM states:
  - IDLE
  - SLOT, with registers hold_instr, hold_pc and a sticky taken_seen.
- IDLE:
  - fill_cond = ENABLE & !stall & !flush & !branch_redirect & id_is_cbranch & cand0_valid & cand0_is_nop & cand1_valid & cand1_eligible.
  - kill_cand1 = fill_cond, in the same cycle.
  - On fill_cond: capture hold_instr/hold_pc from cand1, clear taken_seen, go to SLOT, increment fill_count.
- SLOT (the slot NOP is now in decode; the branch is in EX):
  - sub_valid=1, sub_instr=hold_instr, sub_pc=hold_pc.
  - kill_cand1=0; no new fill is evaluated.
  - If branch_resolved & branch_taken: set taken_seen.
  - annul_slot = taken_seen | (branch_resolved & branch_taken). This is combinational, so it is valid in the resolving cycle.
  - On !stall: return to IDLE. Increment annul_count if annul_slot=1 in that cycle.
  - While stall=1: remain in SLOT with outputs held.
- flush in any state: go to IDLE next cycle; the current-cycle outputs are still driven per the state; no counter update.
  - In IDLE, flush suppresses fill_cond.
- Reset: state=IDLE, hold_instr=INST_NOP, hold_pc=0, taken_seen=0, counters=0.
  - Outputs after reset: kill_cand1=0, sub_valid=0, sub_instr=INST_NOP, sub_pc=0, annul_slot=0.
  - sub_instr/sub_pc read INST_NOP/0 whenever the state is not SLOT.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-SLOT drops the substitution the following cycle; nothing is replayed.

Decomposition:
- Shared package/header: opcode constants, INST_NOP, FSM state encodings, and is_cbranch/is_ctrl/is_system decode functions. The same decode is reused by the decode stage.
- Sub-module sat_counter (width-parameterised saturating incrementer), instantiated twice.

Test Plan:
1. Branch in decode with cand0=NOP and cand1=ADD x5,x6,x7 at PC 0x10 -> kill_cand1=1 that cycle. Next cycle: sub_valid=1, sub_pc=0x10, sub_instr=ADD. fill_count=1.
2. Same setup; EX resolves not-taken -> annul_slot stays 0 and the ADD retires exactly once. Resolves taken -> annul_slot=1 in the resolving cycle and annul_count=1.
3. cand1 is a JAL, cand0 is not a NOP, or cand1_valid=0 -> kill_cand1=0 and sub_valid=0; counters unchanged.
4. stall asserted for 3 cycles in SLOT, with taken resolved in cycle 1 -> sub_valid held for 4 cycles and annul_slot=1 from cycle 1 onward. annul_count increments once, only when stall drops.
5. Fill condition true but flush or branch_redirect high, or ENABLE=0 -> kill_cand1=0. flush in SLOT -> IDLE next cycle, sub_valid=0.
6. Force fill_count to all-ones and perform a fill -> value stays all-ones. Reset in SLOT -> all outputs return to reset values the next cycle.
